// File: rtl/cache_pkg.sv
// Shared types and AXI constants for the cache write-back path.
package cache_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_RESP,
    ST_DONE
  } wb_state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  // AXI AxSIZE code: log2 of bytes per beat.
  function automatic logic [2:0] axi_size(input int unsigned data_w);
    return 3'($clog2(data_w / 8));
  endfunction

endpackage

// File: rtl/axi_wb_unit.sv
// Evicts one cache line as a single AXI INCR write burst, AW then W then B,
// one transaction outstanding at a time.
module axi_wb_unit
  import cache_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int LINE_BYTES = 64,
  parameter int DATA_W     = 32,
  localparam int BEATS     = LINE_BYTES * 8 / DATA_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_wb,
  input  logic [ADDR_W-1:0]       wb_addr,
  input  logic [LINE_BYTES*8-1:0] wb_data,
  output logic                    ready_wb,
  output logic                    wb_err,
  output logic [ADDR_W-1:0]       awaddr,
  output logic [7:0]              awlen,
  output logic [2:0]              awsize,
  output logic [1:0]              awburst,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [DATA_W-1:0]       wdata,
  output logic [DATA_W/8-1:0]     wstrb,
  output logic                    wlast,
  output logic                    wvalid,
  input  logic                    wready,
  input  logic [1:0]              bresp,
  input  logic                    bvalid,
  output logic                    bready
);

  localparam int LINE_W = LINE_BYTES * 8;
  localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  wb_state_t          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [LINE_W-1:0]  line_q, line_d;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; DONE always drains to IDLE so a held request is not re-taken
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (valid_wb)                      state_d = ST_ADDR;
      ST_ADDR: if (awready)                       state_d = ST_DATA;
      ST_DATA: if (wready && cnt_q == LAST_BEAT)  state_d = ST_RESP;
      ST_RESP: if (bvalid)                        state_d = ST_DONE;
      ST_DONE:                                    state_d = ST_IDLE;
      default:                                    state_d = ST_IDLE;
    endcase
  end

  // Output decode: all handshake outputs come from registered state only
  always_comb begin
    awvalid  = (state_q == ST_ADDR);
    wvalid   = (state_q == ST_DATA);
    wlast    = (state_q == ST_DATA) && (cnt_q == LAST_BEAT);
    bready   = (state_q == ST_RESP);
    ready_wb = (state_q == ST_DONE);
    wb_err   = (state_q == ST_DONE) && err_q;
    awaddr   = addr_q;
    awlen    = 8'(BEATS - 1);
    awsize   = axi_size(DATA_W);
    awburst  = AXI_BURST_INCR;
    wdata    = line_q[DATA_W-1:0];
    wstrb    = '1;
  end

  // Datapath: capture on accept, shift one beat per W handshake
  always_comb begin
    addr_d = addr_q;
    line_d = line_q;
    cnt_d  = cnt_q;
    err_d  = err_q;
    unique case (state_q)
      ST_IDLE: if (valid_wb) begin
        addr_d = wb_addr;
        line_d = wb_data;
        cnt_d  = '0;
        err_d  = 1'b0;
      end
      ST_DATA: if (wready) begin
        line_d = line_q >> DATA_W;
        if (cnt_q != LAST_BEAT) cnt_d = cnt_q + 1'b1;
      end
      ST_RESP: if (bvalid) err_d = (bresp != AXI_RESP_OKAY);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  // Payload registers are only meaningful while their valid is high
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    line_q <= line_d;
  end

endmodule

// File: tb/tb_axi_wb_unit.sv
// Directed bench for axi_wb_unit: a scenario table driven through a cycle-level
// AXI slave model, plus held-request and reset-abort sequences.
module tb_axi_wb_unit;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int LINE_W = 512;
  localparam int BEATS  = 16;
  localparam int BUDGET = 200;

  logic                clk = 1'b0;
  logic                rst;
  logic                valid_wb;
  logic [ADDR_W-1:0]   wb_addr;
  logic [LINE_W-1:0]   wb_data;
  logic                ready_wb, wb_err;
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awvalid, awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast, wvalid, wready;
  logic [1:0]          bresp;
  logic                bvalid, bready;

  int checks = 0;
  int errors = 0;

  axi_wb_unit dut (
    .clk(clk), .rst(rst), .valid_wb(valid_wb), .wb_addr(wb_addr), .wb_data(wb_data),
    .ready_wb(ready_wb), .wb_err(wb_err),
    .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] base;
    int          aw_dly;
    logic [15:0] stall_mask;
    logic [1:0]  bresp;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Drive one write-back through a negedge-driven slave model.
  // abort_beat >= 0 asserts rst once that many beats have been delivered.
  task automatic run_wb(input vec_t v, input bit hold, input int abort_beat);
    logic [LINE_W-1:0] line;
    int nb, aw_cyc, aw_hs, last_k;
    bit got;
    bit [15:0] stalled;
    for (int i = 0; i < BEATS; i++) line[i*DATA_W +: DATA_W] = v.base + 32'(i);
    @(negedge clk);
    wb_addr = v.addr; wb_data = line; valid_wb = 1'b1;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    nb = 0; aw_cyc = 0; aw_hs = 0; last_k = -1; got = 1'b0; stalled = '0;
    for (int k = 1; k <= BUDGET && !got; k++) begin
      @(negedge clk);
      if (abort_beat >= 0 && nb == abort_beat) begin
        rst = 1'b1; valid_wb = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
        @(negedge clk);
        chk("abort_awvalid", 64'(awvalid), 64'd0);
        chk("abort_wvalid",  64'(wvalid),  64'd0);
        chk("abort_bready",  64'(bready),  64'd0);
        chk("abort_ready_wb", 64'(ready_wb), 64'd0);
        rst = 1'b0;
        return;
      end
      awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
      if (wb_err && !ready_wb) chk("wb_err_alone", 64'(wb_err), 64'd0);
      if (awvalid) begin
        chk("awaddr",  64'(awaddr),  64'(v.addr));
        chk("awlen",   64'(awlen),   64'd15);
        chk("awsize",  64'(awsize),  64'd2);
        chk("awburst", 64'(awburst), 64'd1);
        chk("aw_before_w", 64'(nb), 64'd0);
        awready = (aw_cyc >= v.aw_dly);
        aw_cyc++;
        if (awready) aw_hs++;
      end
      if (wvalid) begin
        if (nb >= BEATS) begin
          chk("extra_beat", 64'(nb), 64'(BEATS - 1));
        end else begin
          chk("aw_done_first", 64'(aw_hs), 64'd1);
          chk("wdata", 64'(wdata), 64'(v.base + 32'(nb)));
          chk("wlast", 64'(wlast), 64'(nb == BEATS - 1));
          chk("wstrb", 64'(wstrb), 64'hF);
          if (v.stall_mask[nb] && !stalled[nb]) begin
            stalled[nb] = 1'b1;
          end else begin
            wready = 1'b1;
            if (wlast) last_k = k;
            nb++;
          end
        end
      end
      if (bready && last_k >= 0 && k >= last_k + 2) begin
        bvalid = 1'b1; bresp = v.bresp;
      end
      if (ready_wb) begin
        got = 1'b1;
        chk("latency", 64'(k), 64'(v.exp_lat));
        chk("wb_err", 64'(wb_err), 64'(v.exp_err));
        chk("beats", 64'(nb), 64'(BEATS));
        if (!hold) valid_wb = 1'b0;
      end
    end
    if (!got) chk("timeout_ready_wb", 64'd0, 64'd1);
    if (hold) begin
      @(negedge clk);
      valid_wb = 1'b0;
      chk("held_pulse_len", 64'(ready_wb), 64'd0);
    end
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk("post_ready_wb", 64'(ready_wb), 64'd0);
      chk("post_awvalid",  64'(awvalid),  64'd0);
    end
    chk("aw_handshakes", 64'(aw_hs), 64'd1);
  endtask

  vec_t vecs[4];
  vec_t v;

  initial begin
    vecs[0] = '{32'h0000_1040, 32'hA5A5_0000, 0, 16'h0000, 2'b00, 1'b0, 20};
    vecs[1] = '{32'h0000_2000, 32'h1111_0000, 3, 16'h8081, 2'b00, 1'b0, 26};
    vecs[2] = '{32'h0000_3FC0, 32'h2222_0000, 0, 16'h0000, 2'b10, 1'b1, 20};
    vecs[3] = '{32'h0000_0080, 32'h3333_0000, 1, 16'h0002, 2'b11, 1'b1, 22};

    rst = 1'b1; valid_wb = 1'b0; wb_addr = '0; wb_data = '0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    repeat (3) @(negedge clk);
    chk("rst_awvalid",  64'(awvalid),  64'd0);
    chk("rst_wvalid",   64'(wvalid),   64'd0);
    chk("rst_wlast",    64'(wlast),    64'd0);
    chk("rst_bready",   64'(bready),   64'd0);
    chk("rst_ready_wb", 64'(ready_wb), 64'd0);
    chk("rst_wb_err",   64'(wb_err),   64'd0);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) run_wb(vecs[i], 1'b0, -1);

    // Request still high through DONE, dropped in the following cycle
    run_wb(vecs[0], 1'b1, -1);

    // Reset after beat 5, then a fresh burst must restart at beat 0
    run_wb(vecs[1], 1'b0, 6);
    v = '{32'h0000_4000, 32'h4444_0000, 0, 16'h0000, 2'b00, 1'b0, 20};
    run_wb(v, 1'b0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
